// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_pkg
// Description : Shared types and default sizes for the N-core matrix-multiply
//               processor. Holds the DRAM arbiter state encoding and the
//               default core count / DRAM geometry.
// Contents    : arb_state_t             - arbiter FSM state encoding
//               N_CORES_DEF             - default number of cores
//               DRAM_ADDR_W/DRAM_DATA_W - default DRAM address/data widths
// Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

   localparam int N_CORES_DEF = 4;
   localparam int DRAM_ADDR_W = 16;
   localparam int DRAM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

endpackage : mm_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin pick. The search starts one
//               position above the previous winner and wraps, so the last
//               winner always has the lowest priority.
// Ports       : req      in  N      request vector
//               last_gnt in  IDX_W  index of the previous winner
//               gnt      out N      one-hot grant (zero when no request)
//               gnt_idx  out IDX_W  index of the granted requester
//               any_req  out 1      at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import mm_pkg::*;
#(
   parameter int N     = N_CORES_DEF,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_gnt,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any_req
);

   logic             w_found;
   logic [IDX_W-1:0] w_cand;

   always_comb begin : p_pick
      gnt     = '0;
      gnt_idx = '0;
      any_req = |req;
      w_found = 1'b0;
      w_cand  = '0;
      // Offsets 1..N visit every requester once, ending on last_gnt itself.
      for (int i = 1; i <= N; i++) begin
         w_cand = IDX_W'((int'(last_gnt) + i) % N);
         if (!w_found && req[w_cand]) begin
            w_found       = 1'b1;
            gnt_idx       = w_cand;
            gnt[w_cand]   = 1'b1;
         end
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_arbiter
// Description : Shares one single-port data RAM between N_CORES control units.
//               One single-word read or write is in flight at a time; cores
//               are served in round-robin order. Each access ends with a
//               one-cycle ack to its core; read data is returned on rdata.
// Ports       : clk        in  1               system clock, rising edge
//               rst_n      in  1               async active-low reset
//               req        in  N_CORES         per-core request, held to ack
//               req_we     in  N_CORES         per-core 1=write 0=read
//               req_addr   in  N_CORES*ADDR_W  packed per-core addresses
//               req_wdata  in  N_CORES*DATA_W  packed per-core write data
//               ack        out N_CORES         one-cycle completion pulse
//               rdata      out DATA_W          last read result (registered)
//               status     out N_CORES         1 = core has nothing pending
//               ram_addr   out ADDR_W          DRAM address
//               ram_wdata  out DATA_W          DRAM write data
//               ram_we     out 1               DRAM write strobe
//               ram_re     out 1               DRAM read strobe
//               ram_rdata  in  DATA_W          DRAM read data
// Revision    : 1.0 - initial release
// ============================================================================
module dram_arbiter
   import mm_pkg::*;
#(
   parameter int N_CORES = N_CORES_DEF,
   parameter int ADDR_W  = DRAM_ADDR_W,
   parameter int DATA_W  = DRAM_DATA_W,
   parameter int RAM_LAT = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_CORES-1:0]          req,
   input  logic [N_CORES-1:0]          req_we,
   input  logic [N_CORES*ADDR_W-1:0]   req_addr,
   input  logic [N_CORES*DATA_W-1:0]   req_wdata,
   output logic [N_CORES-1:0]          ack,
   output logic [DATA_W-1:0]           rdata,
   output logic [N_CORES-1:0]          status,
   output logic [ADDR_W-1:0]           ram_addr,
   output logic [DATA_W-1:0]           ram_wdata,
   output logic                        ram_we,
   output logic                        ram_re,
   input  logic [DATA_W-1:0]           ram_rdata
);

   localparam int c_IDX_W = $clog2(N_CORES);
   localparam int c_CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   arb_state_t          r_state;
   arb_state_t          w_next_state;
   logic [c_IDX_W-1:0]  r_last_gnt;
   logic [c_IDX_W-1:0]  r_winner;
   logic [N_CORES-1:0]  r_win_oh;
   logic [c_CNT_W-1:0]  r_lat_cnt;
   logic [N_CORES-1:0]  w_gnt;
   logic [c_IDX_W-1:0]  w_gnt_idx;
   logic                w_any_req;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic                w_sel_we;

   rr_arbiter #(
      .N     (N_CORES),
      .IDX_W (c_IDX_W)
   ) u_rr (
      .req      (req),
      .last_gnt (r_last_gnt),
      .gnt      (w_gnt),
      .gnt_idx  (w_gnt_idx),
      .any_req  (w_any_req)
   );

   // One-hot mux of the winning core's request fields.
   always_comb begin : p_sel
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_we    = 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
         if (w_gnt[i]) begin
            w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            w_sel_we    = req_we[i];
         end
      end
   end

   // A core with its request line low has nothing to wait for.
   assign status = ~req;

   always_ff @(posedge clk or negedge rst_n) begin : p_state
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin : p_next
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_any_req) w_next_state = ISSUE;
         // ram_we is high exactly in ISSUE for a write, so it tells the kind.
         ISSUE:   w_next_state = ram_we ? DONE : WAIT;
         WAIT:    if (r_lat_cnt == '0) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Outputs are registered one cycle ahead of the state they belong to:
   // strobes are loaded in IDLE so they are high during ISSUE, and ack is
   // loaded on the way into DONE so it is high during DONE.
   always_ff @(posedge clk or negedge rst_n) begin : p_data
      if (!rst_n) begin
         ack        <= '0;
         rdata      <= '0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         ram_we     <= 1'b0;
         ram_re     <= 1'b0;
         r_last_gnt <= c_IDX_W'(N_CORES - 1);
         r_winner   <= '0;
         r_win_oh   <= '0;
         r_lat_cnt  <= '0;
      end else begin
         ack    <= '0;
         ram_we <= 1'b0;
         ram_re <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_winner  <= w_gnt_idx;
                  r_win_oh  <= w_gnt;
                  ram_addr  <= w_sel_addr;
                  ram_wdata <= w_sel_wdata;
                  ram_we    <= w_sel_we;
                  ram_re    <= ~w_sel_we;
               end
            end
            ISSUE: begin
               if (ram_we) begin
                  ack <= r_win_oh;
               end else begin
                  r_lat_cnt <= c_CNT_W'(RAM_LAT - 1);
               end
            end
            WAIT: begin
               if (r_lat_cnt == '0) begin
                  rdata <= ram_rdata;
                  ack   <= r_win_oh;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 1'b1;
               end
            end
            DONE: begin
               r_last_gnt <= r_winner;
            end
            default: ;
         endcase
      end
   end

endmodule : dram_arbiter
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_arbiter
// Description : Self-checking bench for dram_arbiter with a behavioural DRAM
//               and a transaction-level round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_arbiter;

   localparam int N   = 4;
   localparam int AW  = 16;
   localparam int DW  = 8;
   localparam int LAT = 2;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      req;
   logic [N-1:0]      req_we;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      ack;
   logic [DW-1:0]     rdata;
   logic [N-1:0]      status;
   logic [AW-1:0]     ram_addr;
   logic [DW-1:0]     ram_wdata;
   logic              ram_we;
   logic              ram_re;
   logic [DW-1:0]     ram_rdata;

   int n_vec = 0;
   int n_err = 0;

   dram_arbiter #(
      .N_CORES (N),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .RAM_LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .ack       (ack),
      .rdata     (rdata),
      .status    (status),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_re    (ram_re),
      .ram_rdata (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unwritten DRAM locations read back as a fixed function of the address.
   function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
      return a[7:0] ^ 8'h1C;
   endfunction

   // Behavioural DRAM: data appears LAT cycles after the read strobe.
   logic [DW-1:0] dram_mem [256];
   logic          dram_wr  [256];
   logic [DW-1:0] rd_pipe  [LAT];

   always @(posedge clk) begin
      if (ram_we) begin
         dram_mem[ram_addr[7:0]] <= ram_wdata;
         dram_wr[ram_addr[7:0]]  <= 1'b1;
      end
      if (ram_re)
         rd_pipe[0] <= (dram_wr[ram_addr[7:0]] === 1'b1) ? dram_mem[ram_addr[7:0]]
                                                         : mem_init(ram_addr);
      else
         rd_pipe[0] <= DW'($urandom);
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_rdata = rd_pipe[LAT-1];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      req[i]               = 1'b1;
      req_we[i]            = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req       = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b1;
      req       = 4'b1010;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({ack, ram_we, ram_re, ram_addr, ram_wdata, rdata} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: ack=%b we=%b re=%b addr=%h wdata=%h rdata=%h, want all zero",
                  ack, ram_we, ram_re, ram_addr, ram_wdata, rdata);
      end
      n_vec++;
      if (status !== 4'b0101) begin
         n_err++;
         $display("FAIL reset_status: got %b want 0101", status);
      end
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({ack, ram_we, ram_re, status} !== {4'b0000, 2'b00, 4'b1111}) begin
         n_err++;
         $display("FAIL reset_idle: ack=%b we=%b re=%b status=%b, want 0000 0 0 1111",
                  ack, ram_we, ram_re, status);
      end
   endtask

   task automatic test_single_write();
      logic [N-1:0] exp_ack;
      step();
      set_req(1, 1'b1, 16'h0010, 8'hA5);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         exp_ack = (c == 2) ? 4'b0010 : 4'b0000;
         n_vec++;
         if (ack !== exp_ack) begin
            n_err++;
            $display("FAIL wr_ack c%0d: got %b want %b", c, ack, exp_ack);
         end
         n_vec++;
         if (ram_we !== (c == 1) || ram_re !== 1'b0) begin
            n_err++;
            $display("FAIL wr_strobe c%0d: we=%b re=%b want we=%b re=0", c, ram_we, ram_re, (c == 1));
         end
         if (c == 1) begin
            n_vec++;
            if (ram_addr !== 16'h0010 || ram_wdata !== 8'hA5) begin
               n_err++;
               $display("FAIL wr_bus: addr=%h wdata=%h want 0010 a5", ram_addr, ram_wdata);
            end
         end
         n_vec++;
         if (status[1] !== (c > 2)) begin
            n_err++;
            $display("FAIL wr_status c%0d: got %b want %b", c, status[1], (c > 2));
         end
         step();
         if (c == 2) req[1] = 1'b0;
      end
   endtask

   task automatic test_single_read();
      logic [N-1:0] exp_ack;
      step();
      set_req(2, 1'b0, 16'h0020, 8'h00);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         exp_ack = (c == 4) ? 4'b0100 : 4'b0000;
         n_vec++;
         if (ack !== exp_ack) begin
            n_err++;
            $display("FAIL rd_ack c%0d: got %b want %b", c, ack, exp_ack);
         end
         n_vec++;
         if (ram_re !== (c == 1) || ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL rd_strobe c%0d: re=%b we=%b want re=%b we=0", c, ram_re, ram_we, (c == 1));
         end
         if (c == 1) begin
            n_vec++;
            if (ram_addr !== 16'h0020) begin
               n_err++;
               $display("FAIL rd_addr: got %h want 0020", ram_addr);
            end
         end
         if (c == 4) begin
            n_vec++;
            if (rdata !== 8'h3C) begin
               n_err++;
               $display("FAIL rd_data: got %h want 3c", rdata);
            end
         end
         step();
         if (c == 4) req[2] = 1'b0;
      end
   endtask

   task automatic test_all_reads();
      logic [N-1:0] exp_ack;
      logic         exp_re;
      int           k;
      do_reset();
      step();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(16'h0030 + i), 8'h00);
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         exp_ack = '0;
         k = (c - 4) / 5;
         if (c >= 4 && (c - 4) % 5 == 0 && k < N) exp_ack[k] = 1'b1;
         exp_re = (c >= 1) && ((c - 1) % 5 == 0) && ((c - 1) / 5 < N);
         n_vec++;
         if (ack !== exp_ack) begin
            n_err++;
            $display("FAIL all_ack c%0d: got %b want %b", c, ack, exp_ack);
         end
         n_vec++;
         if (ram_re !== exp_re || ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL all_strobe c%0d: re=%b we=%b want re=%b we=0", c, ram_re, ram_we, exp_re);
         end
         if (exp_ack != '0) begin
            n_vec++;
            if (rdata !== mem_init(AW'(16'h0030 + k))) begin
               n_err++;
               $display("FAIL all_data core%0d: got %h want %h", k, rdata, mem_init(AW'(16'h0030 + k)));
            end
         end
         step();
         req = req & ~exp_ack;
      end
   endtask

   task automatic test_fairness();
      logic [N-1:0] exp_ack;
      int           order [4] = '{3, 0, 3, 0};
      step();
      set_req(0, 1'b0, 16'h0040, 8'h00);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         exp_ack = (c == 4) ? 4'b0001 : 4'b0000;
         n_vec++;
         if (ack !== exp_ack) begin
            n_err++;
            $display("FAIL fair_pre_ack c%0d: got %b want %b", c, ack, exp_ack);
         end
         step();
         if (c == 4) req[0] = 1'b0;
      end
      set_req(0, 1'b0, 16'h0041, 8'h00);
      set_req(3, 1'b0, 16'h0043, 8'h00);
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         exp_ack = '0;
         if (c >= 4 && (c - 4) % 5 == 0 && (c - 4) / 5 < 4) exp_ack[order[(c - 4) / 5]] = 1'b1;
         n_vec++;
         if (ack !== exp_ack) begin
            n_err++;
            $display("FAIL fair_ack c%0d: got %b want %b", c, ack, exp_ack);
         end
         if (exp_ack[3] || exp_ack[0]) begin
            n_vec++;
            if (rdata !== (exp_ack[3] ? 8'h5F : 8'h5D)) begin
               n_err++;
               $display("FAIL fair_data c%0d: got %h want %h", c, rdata, exp_ack[3] ? 8'h5F : 8'h5D);
            end
         end
         step();
         if (c == 19) req = '0;
      end
   endtask

   task automatic test_reset_midflight();
      step();
      set_req(0, 1'b0, 16'h0021, 8'h00);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if (ack !== '0 || ram_re !== (c == 1)) begin
            n_err++;
            $display("FAIL mid_pre c%0d: ack=%b re=%b want ack=0000 re=%b", c, ack, ram_re, (c == 1));
         end
         if (c < 2) step();
      end
      // Arbiter is now in WAIT with the read outstanding.
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (ack !== '0 || ram_re !== 1'b0 || ram_we !== 1'b0 || rdata !== '0) begin
         n_err++;
         $display("FAIL mid_rst: ack=%b re=%b we=%b rdata=%h want 0 0 0 00", ack, ram_re, ram_we, rdata);
      end
      req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_vec++;
         if (ack !== '0 || ram_re !== 1'b0) begin
            n_err++;
            $display("FAIL mid_quiet c%0d: ack=%b re=%b want 0000 0", c, ack, ram_re);
         end
      end
      step();
      set_req(0, 1'b0, 16'h0021, 8'h00);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         n_vec++;
         if (ack !== ((c == 4) ? 4'b0001 : 4'b0000)) begin
            n_err++;
            $display("FAIL mid_rereq_ack c%0d: got %b want %b", c, ack, (c == 4) ? 4'b0001 : 4'b0000);
         end
         if (c == 4) begin
            n_vec++;
            if (rdata !== 8'h3D) begin
               n_err++;
               $display("FAIL mid_rereq_data: got %h want 3d", rdata);
            end
         end
         step();
         if (c == 4) req[0] = 1'b0;
      end
   endtask

   task automatic test_drop_req();
      step();
      set_req(1, 1'b0, 16'h0022, 8'h00);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         n_vec++;
         if (ack !== ((c == 4) ? 4'b0010 : 4'b0000)) begin
            n_err++;
            $display("FAIL drop_ack c%0d: got %b want %b", c, ack, (c == 4) ? 4'b0010 : 4'b0000);
         end
         n_vec++;
         if (ram_re !== (c == 1) || ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL drop_strobe c%0d: re=%b we=%b want re=%b we=0", c, ram_re, ram_we, (c == 1));
         end
         n_vec++;
         if (status[1] !== (c >= 1)) begin
            n_err++;
            $display("FAIL drop_status c%0d: got %b want %b", c, status[1], (c >= 1));
         end
         if (c == 4) begin
            n_vec++;
            if (rdata !== 8'h3E) begin
               n_err++;
               $display("FAIL drop_data: got %h want 3e", rdata);
            end
         end
         step();
         if (c == 0) req[1] = 1'b0;
      end
   endtask

   task automatic rand_req(input int i);
      set_req(i, 1'($urandom_range(1)), AW'(16'h0080 + $urandom_range(31)), DW'($urandom));
   endtask

   // Transaction-level model: whenever the arbiter is free and anyone asks,
   // the next requester after the last winner is served; a write finishes
   // 2 cycles later, a read 2+LAT cycles later, then one idle cycle follows.
   task automatic test_random(input int n_cycles);
      logic [DW-1:0] ref_mem [256];
      bit            ref_wr  [256];
      int            last, win, issue_c, ack_c, idle_at, j;
      bit            active, found, ack_now;
      logic          m_we, exp_we, exp_re;
      logic [AW-1:0] m_addr;
      logic [DW-1:0] m_wdata, exp_rdata;
      logic [N-1:0]  done, exp_ack;

      do_reset();
      last = N - 1; win = 0; issue_c = -1; ack_c = -1; idle_at = 0;
      active = 0; exp_rdata = '0; done = '0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0;

      for (int cyc = 0; cyc < n_cycles; cyc++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (done[i]) begin
               done[i] = 1'b0;
               if ($urandom_range(1) == 1) rand_req(i);
               else req[i] = 1'b0;
            end else if (active && win == i) begin
               if (req[i]) begin
                  req_addr[i*AW +: AW]  = AW'($urandom);
                  req_wdata[i*DW +: DW] = DW'($urandom);
                  req_we[i]             = 1'($urandom_range(1));
                  if ($urandom_range(15) == 0) req[i] = 1'b0;
               end
            end else if (!req[i] && $urandom_range(2) == 0) begin
               rand_req(i);
            end
         end

         @(negedge clk);
         exp_ack = '0;
         exp_we  = 1'b0;
         exp_re  = 1'b0;
         ack_now = active && (cyc == ack_c);
         if (ack_now) begin
            exp_ack[win] = 1'b1;
            if (!m_we) exp_rdata = ref_wr[m_addr[7:0]] ? ref_mem[m_addr[7:0]] : mem_init(m_addr);
         end
         if (active && cyc == issue_c) begin
            exp_we = m_we;
            exp_re = ~m_we;
         end

         n_vec++;
         if (ack !== exp_ack) begin
            n_err++;
            $display("FAIL rnd_ack cyc%0d: got %b want %b", cyc, ack, exp_ack);
         end
         n_vec++;
         if (ram_we !== exp_we || ram_re !== exp_re) begin
            n_err++;
            $display("FAIL rnd_strobe cyc%0d: we=%b re=%b want we=%b re=%b", cyc, ram_we, ram_re, exp_we, exp_re);
         end
         if (exp_we || exp_re) begin
            n_vec++;
            if (ram_addr !== m_addr || (exp_we && ram_wdata !== m_wdata)) begin
               n_err++;
               $display("FAIL rnd_bus cyc%0d: addr=%h wdata=%h want %h %h", cyc, ram_addr, ram_wdata, m_addr, m_wdata);
            end
         end
         n_vec++;
         if (rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL rnd_rdata cyc%0d: got %h want %h", cyc, rdata, exp_rdata);
         end
         n_vec++;
         if (status !== ~req) begin
            n_err++;
            $display("FAIL rnd_status cyc%0d: got %b want %b", cyc, status, ~req);
         end

         if (ack_now) begin
            if (m_we) begin
               ref_mem[m_addr[7:0]] = m_wdata;
               ref_wr[m_addr[7:0]]  = 1'b1;
            end
            last     = win;
            active   = 0;
            idle_at  = cyc + 1;
            done[win] = 1'b1;
         end else if (!active && cyc >= idle_at && req != '0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
               j = (last + k) % N;
               if (!found && req[j]) begin
                  found = 1;
                  win   = j;
               end
            end
            active  = 1;
            m_we    = req_we[win];
            m_addr  = req_addr[win*AW +: AW];
            m_wdata = req_wdata[win*DW +: DW];
            issue_c = cyc + 1;
            ack_c   = cyc + (m_we ? 2 : 2 + LAT);
         end
      end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_all_reads();
      test_fairness();
      test_reset_midflight();
      test_drop_req();
      test_random(600);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within time limit (vectors %0d, errors %0d)", n_vec, n_err);
      $fatal(1, "timeout");
   end

endmodule : tb_dram_arbiter
`default_nettype wire

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Arbitrates a single shared data RAM (DRAM) between the N_CORES per-core control units of the N-core matrix-multiply processor.
- Each core raises a single-word read or write request. The arbiter grants one core at a time in round-robin order, sequences the RAM strobes, and returns read data.
- It pulses a per-core ack and drives a per-core status bit back to each control unit's status input, so a core stalls while its DRAM access is pending.

Parameters:
- N_CORES, 4, number of requesting cores (≥2)
- ADDR_W, 16, DRAM address width
- DATA_W, 8, DRAM data width
- RAM_LAT, 2, DRAM read latency in cycles from ram_re to valid ram_rdata (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_CORES  per-core request; held until ack
- req_we  in  N_CORES  per-core 1=write, 0=read; valid while req
- req_addr  in  N_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_CORES*DATA_W  per-core write data, same packing
- ack  out  N_CORES  one-cycle completion pulse to the granted core
- rdata  out  DATA_W  registered read data; valid in the ack cycle, held until the next read completes
- status  out  N_CORES  1 = core i has no pending request; 0 while req[i] is high and not yet acked
- ram_addr  out  ADDR_W  DRAM address
- ram_wdata  out  DATA_W  DRAM write data
- ram_we  out  1  DRAM write strobe, one cycle
- ram_re  out  1  DRAM read strobe, one cycle
- ram_rdata  in  DATA_W  DRAM read data

Behaviour:
- Reset (asynchronous, takes effect at any point, including mid-transaction):
  - state=IDLE; ack=0; ram_we=ram_re=0; ram_addr=0; ram_wdata=0; rdata=0.
  - last-grant pointer = N_CORES-1, so core 0 has top priority first.
  - status = ~req, combinational.
  - An in-flight access is abandoned with no ack. The requester must re-request.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if |req, pick the winner via round-robin, searching from last_gnt+1 upward with wrap. Latch winner index, we, addr and wdata, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle): ram_addr/ram_wdata come from the latched values.
    - Write: ram_we=1, next state DONE.
    - Read: ram_re=1, lat_cnt=RAM_LAT-1, next state WAIT.
  - WAIT: lat_cnt decrements each cycle. When lat_cnt==0, capture ram_rdata into rdata and go to DONE. With RAM_LAT=1, WAIT lasts exactly 1 cycle.
  - DONE (1 cycle): ack[winner]=1, last_gnt<=winner, next state IDLE.
- Latency, counting the IDLE cycle in which req is first sampled as cycle 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+RAM_LAT.
  - There is 1 bubble cycle (IDLE) between consecutive transactions.
- Requester rule:
  - Deassert req, or change it to the next request, on the edge at which ack=1 is sampled.
  - Requests are latched in IDLE. Changing addr/wdata/we after the grant has no effect.
  - Dropping req before ack does not cancel the transaction; the ack is still issued.
- Simultaneous requests: round-robin order only. The last winner has the lowest priority next time. A continuously requesting core waits at most N_CORES-1 transactions.
- ram_we and ram_re are never high together and are never high outside ISSUE.
- Outputs ack, ram_* and rdata are registered. status is combinational.

Decomposition:
- Shared package mm_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, DONE}.
  - Default constants N_CORES_DEF, DRAM_ADDR_W, DRAM_DATA_W.
- Sub-module rr_arbiter (combinational round-robin pick):
  - Inputs: req[N], last_gnt index.
  - Outputs: one-hot gnt[N], gnt_idx, any_req.
  - Instantiated once. FSM, counter and data registers stay in dram_arbiter.

Test Plan:
- Reset then single write: core1 req, we=1, addr=0x0010, wdata=0xA5 → ram_we=1 with ram_addr=0x0010 and ram_wdata=0xA5 in cycle 1; ack[1] in cycle 2; status[1]=0 during cycles 0–2, then 1.
- Single read, RAM_LAT=2, memory returns 0x3C: core2 reads 0x0020 → ram_re in cycle 1; ack[2] in cycle 4; rdata=0x3C in the ack cycle.
- All 4 cores request reads at once after reset → ack order core0, core1, core2, core3, each 5 cycles apart; no overlapping strobes.
- Core0 holds req continuously with core3 also requesting, last_gnt=0 → core3 served next, then core0 (alternation, no starvation).
- Reset asserted in WAIT state → ack stays 0 and ram_re=0 immediately; after release, core0 re-requests and completes with normal latency.
- Core1 drops req in the ISSUE cycle → ack[1] still pulses in the DONE cycle; the arbiter returns to IDLE with no further grant.
